// File: rtl/isa_dispatch_pkg.sv
// Shared types and field constants for the instruction dispatcher.
package isa_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      DONE
   } state_t;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 29;
   localparam int LCNT_MSB = 7;
   localparam int LCNT_LSB = 0;
   localparam int LOOP_BIT_DEF = 2;
   localparam int END_BIT_DEF = 3;

endpackage

// File: rtl/isa_dispatch_if.sv
// Host instruction bus: valid/ready handshake carrying one word.
interface isa_dispatch_if #(
   parameter int BIT_DEPTH = 32
);
   logic                 instr_valid;
   logic                 instr_ready;
   logic [BIT_DEPTH-1:0] instr_data;

   modport master (
      output instr_valid,
      output instr_data,
      input  instr_ready
   );

   modport slave (
      input  instr_valid,
      input  instr_data,
      output instr_ready
   );
endinterface

// File: rtl/isa_dispatch_fifo.sv
// Instruction buffer: synchronous FIFO, host push via handshake,
// pop strobe from the dispatcher FSM, flushed by rst.
module isa_dispatch_fifo #(
   parameter int BIT_DEPTH = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int LOG_FIFO_DEPTH = 2
) (
   input  logic                 Clk,
   input  logic                 rst,
   isa_dispatch_if.slave        host,
   input  logic                 pop,
   output logic [BIT_DEPTH-1:0] head,
   output logic                 empty,
   output logic                 full
);
   logic [BIT_DEPTH-1:0]    mem [FIFO_DEPTH];
   logic [LOG_FIFO_DEPTH:0] wr_ptr;
   logic [LOG_FIFO_DEPTH:0] rd_ptr;
   logic                    push;

   // Extra pointer bit separates full from empty when indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full = (wr_ptr[LOG_FIFO_DEPTH] != rd_ptr[LOG_FIFO_DEPTH]) &&
      (wr_ptr[LOG_FIFO_DEPTH-1:0] == rd_ptr[LOG_FIFO_DEPTH-1:0]);
   assign host.instr_ready = !full;
   assign push = host.instr_valid && !full;
   assign head = mem[rd_ptr[LOG_FIFO_DEPTH-1:0]];

   always_ff @(posedge Clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr[LOG_FIFO_DEPTH-1:0]] <= host.instr_data;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end
endmodule

// File: rtl/isa_dispatch.sv
// Dispatcher FSM in front of the MAC microcode sequencer.
// Optional watchdog abort of RUN enabled by ISA_DISPATCH_WDOG_EN.
module isa_dispatch
   import isa_pkg::*;
#(
   parameter int BIT_DEPTH = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int LOG_FIFO_DEPTH = 2,
   parameter int LOOP_BIT = LOOP_BIT_DEF,
   parameter int END_BIT = END_BIT_DEF,
   parameter int WDOG_CYCLES = 64
) (
   input  logic                 Clk,
   input  logic                 rst,
   isa_dispatch_if.slave        host,
   input  logic [7:0]           ctrl_in,
   output logic [BIT_DEPTH-1:0] seq_inputs,
   output logic                 seq_en,
   output logic                 seq_rst,
   output logic                 seq_skip,
   output logic                 busy,
   output logic                 done_pulse,
`ifdef ISA_DISPATCH_WDOG_EN
   output logic                 wdog_err,
`endif
   output logic [15:0]          instr_count
);
   state_t               state;
   logic [7:0]           loop_cnt;
   logic                 rst_q;
   logic                 pop;
   logic                 empty;
   logic                 full;
   logic [BIT_DEPTH-1:0] head;
   logic                 fin;
   logic                 loop_hit;

`ifdef ISA_DISPATCH_WDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYCLES) + 1;
   logic [WDOG_W-1:0] wdog_cnt;
   logic              abort;
`else
   logic unused_ok;
   assign unused_ok = ^{ctrl_in, WDOG_CYCLES[0], full};
`endif

   isa_dispatch_fifo #(
      .BIT_DEPTH      (BIT_DEPTH),
      .FIFO_DEPTH     (FIFO_DEPTH),
      .LOG_FIFO_DEPTH (LOG_FIFO_DEPTH)
   ) u_fifo (
      .Clk   (Clk),
      .rst   (rst),
      .host  (host),
      .pop   (pop),
      .head  (head),
      .empty (empty),
      .full  (full)
   );

   assign fin = ctrl_in[END_BIT];
   assign loop_hit = ctrl_in[LOOP_BIT] && !fin;
   assign seq_skip = (state == RUN) && loop_hit && (loop_cnt != 8'd0);
   assign pop = !rst && !empty && ((state == IDLE) || (state == DONE));
   assign busy = (state != IDLE);
   assign seq_rst = rst || rst_q;

   always_ff @(posedge Clk) begin
      if (rst) begin
         state <= IDLE;
         seq_inputs <= '0;
         seq_en <= 1'b0;
         rst_q <= 1'b0;
         done_pulse <= 1'b0;
         instr_count <= 16'd0;
         loop_cnt <= 8'd0;
`ifdef ISA_DISPATCH_WDOG_EN
         wdog_cnt <= '0;
         abort <= 1'b0;
         wdog_err <= 1'b0;
`endif
      end else begin
         rst_q <= 1'b0;
         done_pulse <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pop) begin
                  state <= LOAD;
                  seq_inputs <= head;
                  loop_cnt <= head[LCNT_MSB:LCNT_LSB];
                  rst_q <= 1'b1;
               end
            end
            LOAD: begin
`ifdef ISA_DISPATCH_WDOG_EN
               wdog_cnt <= '0;
               if (abort) begin
                  abort <= 1'b0;
                  state <= DONE;
                  done_pulse <= 1'b1;
               end else begin
                  state <= RUN;
                  seq_en <= 1'b1;
               end
`else
               state <= RUN;
               seq_en <= 1'b1;
`endif
            end
            RUN: begin
               if (fin) begin
                  state <= DONE;
                  seq_en <= 1'b0;
                  done_pulse <= 1'b1;
               end else begin
                  if (seq_skip) begin
                     loop_cnt <= loop_cnt - 8'd1;
                  end
`ifdef ISA_DISPATCH_WDOG_EN
                  wdog_cnt <= wdog_cnt + 1'b1;
                  if (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1)) begin
                     state <= LOAD;
                     abort <= 1'b1;
                     seq_en <= 1'b0;
                     rst_q <= 1'b1;
                     wdog_err <= 1'b1;
                  end
`endif
               end
            end
            DONE: begin
               instr_count <= instr_count + 16'd1;
               if (pop) begin
                  state <= LOAD;
                  seq_inputs <= head;
                  loop_cnt <= head[LCNT_MSB:LCNT_LSB];
                  rst_q <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
